// File: rtl/vga_timing.sv
// VGA raster timing generator.
// A clock-enable divider turns the board clock into a pixel tick; horizontal and
// vertical counters advance on that tick. Sync and blanking flags are registered
// from the next-state counters, so they always match the (row, col) they sit beside.
module vga_timing #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       pix_tick,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       hsync,
  output logic       vsync,
  output logic       hnotactive,
  output logic       vnotactive,
  output logic       active,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned HTotalI = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotalI = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Boundaries kept 11 bits wide so an end-of-line value of 1024 still fits.
  localparam logic [10:0] HActEnd   = 11'(H_ACTIVE);
  localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VActEnd   = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  HMax      = 10'(HTotalI - 1);
  localparam logic [9:0]  VMax      = 10'(VTotalI - 1);
  localparam logic [DivW-1:0] DivMax = DivW'((CLK_DIV > 0) ? CLK_DIV - 1 : 0);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing: CLK_DIV must be >= 1");
  end
  if (HTotalI > 1024 || VTotalI > 1024) begin : g_bad_total
    $error("vga_timing: H_TOTAL and V_TOTAL must be <= 1024");
  end

  typedef enum logic [1:0] {PhActive, PhFront, PhSync, PhBack} phase_e;

  // Classify a counter value into its raster phase.
  function automatic phase_e phase_of(logic [9:0] cnt, logic [10:0] act_end,
                                      logic [10:0] sync_beg, logic [10:0] sync_end);
    logic [10:0] c;
    c = {1'b0, cnt};
    if (c < act_end)       return PhActive;
    else if (c < sync_beg) return PhFront;
    else if (c < sync_end) return PhSync;
    else                   return PhBack;
  endfunction

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      col_q, col_d;
  logic [9:0]      row_q, row_d;
  logic [7:0]      fc_q, fc_d;
  logic            fs_d;
  logic            tick;
  phase_e          h_ph_q, h_ph_d;
  phase_e          v_ph_q, v_ph_d;
  logic            pix_tick_q, hsync_q, vsync_q, hna_q, vna_q, active_q, fs_q;

  // Next-state: divider, raster counters, frame bookkeeping and phases.
  always_comb begin
    tick   = (div_q == DivMax);
    div_d  = tick ? '0 : div_q + 1'b1;
    col_d  = col_q;
    row_d  = row_q;
    fc_d   = fc_q;
    fs_d   = 1'b0;
    if (tick) begin
      if (col_q == HMax) begin
        col_d = '0;
        if (row_q == VMax) begin
          row_d = '0;
          fs_d  = 1'b1;
          fc_d  = fc_q + 8'd1;
        end else begin
          row_d = row_q + 10'd1;
        end
      end else begin
        col_d = col_q + 10'd1;
      end
    end
    h_ph_d = phase_of(col_d, HActEnd, HSyncBeg, HSyncEnd);
    v_ph_d = phase_of(row_d, VActEnd, VSyncBeg, VSyncEnd);
  end

  // State and registered outputs; flags come from the next phase so they line up
  // with the counters on the same edge. Between ticks everything re-registers itself.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      fc_q       <= '0;
      h_ph_q     <= PhActive;
      v_ph_q     <= PhActive;
      pix_tick_q <= 1'b0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      hna_q      <= 1'b0;
      vna_q      <= 1'b0;
      active_q   <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      col_q      <= col_d;
      row_q      <= row_d;
      fc_q       <= fc_d;
      h_ph_q     <= h_ph_d;
      v_ph_q     <= v_ph_d;
      pix_tick_q <= tick;
      hsync_q    <= (h_ph_d == PhSync) ? SYNC_POL : ~SYNC_POL;
      vsync_q    <= (v_ph_d == PhSync) ? SYNC_POL : ~SYNC_POL;
      hna_q      <= (h_ph_d != PhActive);
      vna_q      <= (v_ph_d != PhActive);
      active_q   <= (h_ph_d == PhActive) && (v_ph_d == PhActive);
      fs_q       <= fs_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign col         = col_q;
  assign row         = row_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hnotactive  = hna_q;
  assign vnotactive  = vna_q;
  assign active      = active_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: default timing (CLK_DIV=2), a CLK_DIV=1
// active-high-sync copy, and a tiny raster (8x6) for vertical and frame checks.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n, rst_s;
  always #5 clk = ~clk;

  // Default instance
  logic       d_pt, d_hs, d_vs, d_hna, d_vna, d_act, d_fs;
  logic [9:0] d_col, d_row;
  logic [7:0] d_fc;
  // CLK_DIV=1, SYNC_POL=1 instance
  logic       o_pt, o_hs, o_vs, o_hna, o_vna, o_act, o_fs;
  logic [9:0] o_col, o_row;
  logic [7:0] o_fc;
  // Small raster: H 4+1+2+1=8, V 3+1+1+1=6, CLK_DIV=1
  logic       s_pt, s_hs, s_vs, s_hna, s_vna, s_act, s_fs;
  logic [9:0] s_col, s_row;
  logic [7:0] s_fc;

  vga_timing u_def (
    .CLK(clk), .RST(rst_n), .pix_tick(d_pt), .col(d_col), .row(d_row), .hsync(d_hs),
    .vsync(d_vs), .hnotactive(d_hna), .vnotactive(d_vna), .active(d_act),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_div1 (
    .CLK(clk), .RST(rst_n), .pix_tick(o_pt), .col(o_col), .row(o_row), .hsync(o_hs),
    .vsync(o_vs), .hnotactive(o_hna), .vnotactive(o_vna), .active(o_act),
    .frame_start(o_fs), .frame_count(o_fc)
  );

  vga_timing #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_small (
    .CLK(clk), .RST(rst_s), .pix_tick(s_pt), .col(s_col), .row(s_row), .hsync(s_hs),
    .vsync(s_vs), .hnotactive(s_hna), .vnotactive(s_vna), .active(s_act),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  typedef struct {
    int   k;   // CLK edges since reset release
    int   col;
    int   row;
    logic pt, hs, vs, hna, vna, act, fs;
    int   fc;
  } vec_t;

  vec_t def_tbl[$];
  vec_t sml_tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  function automatic vec_t mk(int k, int c, int r, logic pt, logic hs, logic vs, logic hna,
                              logic vna, logic act, logic fs, int fc);
    vec_t v;
    v.k = k; v.col = c; v.row = r; v.pt = pt; v.hs = hs; v.vs = vs;
    v.hna = hna; v.vna = vna; v.act = act; v.fs = fs; v.fc = fc;
    return v;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0d, expected %0d", nm, k, got, exp);
    end
  endtask

  // Advance to k edges after release, then sample 1 time unit past the edge.
  task automatic step_to(int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    int   oc;
    int   first;
    // Default timing, row 0 and the first line wrap.
    //               k     col  row pt hs vs hna vna act fs fc
    def_tbl.push_back(mk(0,    0,   0, 0, 1, 1, 0,  0,  1,  0, 0));
    def_tbl.push_back(mk(1,    0,   0, 0, 1, 1, 0,  0,  1,  0, 0));
    def_tbl.push_back(mk(2,    1,   0, 1, 1, 1, 0,  0,  1,  0, 0));
    def_tbl.push_back(mk(3,    1,   0, 0, 1, 1, 0,  0,  1,  0, 0));
    def_tbl.push_back(mk(4,    2,   0, 1, 1, 1, 0,  0,  1,  0, 0));
    def_tbl.push_back(mk(1278, 639, 0, 1, 1, 1, 0,  0,  1,  0, 0));
    def_tbl.push_back(mk(1280, 640, 0, 1, 1, 1, 1,  0,  0,  0, 0));
    def_tbl.push_back(mk(1310, 655, 0, 1, 1, 1, 1,  0,  0,  0, 0));
    def_tbl.push_back(mk(1312, 656, 0, 1, 0, 1, 1,  0,  0,  0, 0));
    def_tbl.push_back(mk(1313, 656, 0, 0, 0, 1, 1,  0,  0,  0, 0));
    def_tbl.push_back(mk(1502, 751, 0, 1, 0, 1, 1,  0,  0,  0, 0));
    def_tbl.push_back(mk(1504, 752, 0, 1, 1, 1, 1,  0,  0,  0, 0));
    def_tbl.push_back(mk(1598, 799, 0, 1, 1, 1, 1,  0,  0,  0, 0));
    def_tbl.push_back(mk(1600, 0,   1, 1, 1, 1, 0,  0,  1,  0, 0));
    def_tbl.push_back(mk(1601, 0,   1, 0, 1, 1, 0,  0,  1,  0, 0));
    // Small raster: 48 ticks per frame, hsync on col 5..6, vsync on row 4.
    sml_tbl.push_back(mk(0,     0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    sml_tbl.push_back(mk(1,     1, 0, 1, 1, 1, 0, 0, 1, 0, 0));
    sml_tbl.push_back(mk(4,     4, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    sml_tbl.push_back(mk(5,     5, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    sml_tbl.push_back(mk(6,     6, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    sml_tbl.push_back(mk(7,     7, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    sml_tbl.push_back(mk(8,     0, 1, 1, 1, 1, 0, 0, 1, 0, 0));
    sml_tbl.push_back(mk(24,    0, 3, 1, 1, 1, 0, 1, 0, 0, 0));
    sml_tbl.push_back(mk(31,    7, 3, 1, 1, 1, 1, 1, 0, 0, 0));
    sml_tbl.push_back(mk(32,    0, 4, 1, 1, 0, 0, 1, 0, 0, 0));
    sml_tbl.push_back(mk(37,    5, 4, 1, 0, 0, 1, 1, 0, 0, 0));
    sml_tbl.push_back(mk(39,    7, 4, 1, 1, 0, 1, 1, 0, 0, 0));
    sml_tbl.push_back(mk(40,    0, 5, 1, 1, 1, 0, 1, 0, 0, 0));
    sml_tbl.push_back(mk(47,    7, 5, 1, 1, 1, 1, 1, 0, 0, 0));
    sml_tbl.push_back(mk(48,    0, 0, 1, 1, 1, 0, 0, 1, 1, 1));
    sml_tbl.push_back(mk(49,    1, 0, 1, 1, 1, 0, 0, 1, 0, 1));
    sml_tbl.push_back(mk(96,    0, 0, 1, 1, 1, 0, 0, 1, 1, 2));
    sml_tbl.push_back(mk(12287, 7, 5, 1, 1, 1, 1, 1, 0, 0, 255));
    sml_tbl.push_back(mk(12288, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0));
    sml_tbl.push_back(mk(12307, 3, 2, 1, 1, 1, 0, 0, 1, 0, 0));

    rst_n = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("def_rst_held_col", -1, d_col, 0);
    chk("def_rst_held_hs", -1, d_hs, 1);
    chk("div1_rst_held_hs", -1, o_hs, 0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    foreach (def_tbl[i]) begin
      vec_t v;
      v = def_tbl[i];
      step_to(v.k);
      chk("def_col", v.k, d_col, v.col);
      chk("def_row", v.k, d_row, v.row);
      chk("def_pix_tick", v.k, d_pt, v.pt);
      chk("def_hsync", v.k, d_hs, v.hs);
      chk("def_vsync", v.k, d_vs, v.vs);
      chk("def_hna", v.k, d_hna, v.hna);
      chk("def_vna", v.k, d_vna, v.vna);
      chk("def_active", v.k, d_act, v.act);
      chk("def_frame_start", v.k, d_fs, v.fs);
      chk("def_frame_count", v.k, d_fc, v.fc);
      // CLK_DIV=1 copy advances one pixel per edge; active-high sync.
      oc = v.k % 800;
      chk("div1_col", v.k, o_col, oc);
      chk("div1_row", v.k, o_row, v.k / 800);
      chk("div1_pix_tick", v.k, o_pt, (v.k >= 1) ? 1 : 0);
      chk("div1_hsync", v.k, o_hs, (oc >= 656 && oc < 752) ? 1 : 0);
    end

    @(negedge clk);
    rst_s = 1'b1;
    cyc   = 0;
    foreach (sml_tbl[i]) begin
      vec_t v;
      v = sml_tbl[i];
      step_to(v.k);
      chk("sml_col", v.k, s_col, v.col);
      chk("sml_row", v.k, s_row, v.row);
      chk("sml_pix_tick", v.k, s_pt, v.pt);
      chk("sml_hsync", v.k, s_hs, v.hs);
      chk("sml_vsync", v.k, s_vs, v.vs);
      chk("sml_hna", v.k, s_hna, v.hna);
      chk("sml_vna", v.k, s_vna, v.vna);
      chk("sml_active", v.k, s_act, v.act);
      chk("sml_frame_start", v.k, s_fs, v.fs);
      chk("sml_frame_count", v.k, s_fc, v.fc);
    end

    // Mid-frame asynchronous reset between clock edges.
    @(negedge clk);
    rst_s = 1'b0;
    #1;
    chk("async_rst_col", -1, s_col, 0);
    chk("async_rst_row", -1, s_row, 0);
    chk("async_rst_hsync", -1, s_hs, 1);
    chk("async_rst_vsync", -1, s_vs, 1);
    chk("async_rst_active", -1, s_act, 1);
    chk("async_rst_hna", -1, s_hna, 0);
    chk("async_rst_vna", -1, s_vna, 0);
    chk("async_rst_pix_tick", -1, s_pt, 0);
    chk("async_rst_frame_count", -1, s_fc, 0);
    chk("async_rst_frame_start", -1, s_fs, 0);

    // After release, first frame_start must come after exactly one full frame.
    @(negedge clk);
    rst_s = 1'b1;
    first = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (s_fs === 1'b1) begin
        first = i;
        break;
      end
    end
    chk("first_frame_start_after_reset", first, first, 48);
    chk("frame_count_after_first_frame", first, s_fc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
